// File: rtl/timekeeper_pkg.sv
// Shared types, limits and arithmetic helpers for the multi-alarm timekeeper.
// TIMEKEEPER_SNOOZE_EN adds the SNOOZED alarm state.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        AL_OFF     = 2'd0,
        AL_ARMED   = 2'd1,
`ifdef TIMEKEEPER_SNOOZE_EN
        AL_SNOOZED = 2'd3,
`endif
        AL_RINGING = 2'd2
    } alarm_state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int SNOOZE_S = 300;

    // Modular add of 0..2; the sum is always below twice the modulus.
    function automatic logic [6:0] wrap_add(input logic [6:0] val,
                                            input logic [1:0] inc,
                                            input logic [6:0] modulus);
        logic [6:0] sum_s;
        sum_s = val + {5'd0, inc};
        if (sum_s >= modulus) begin
            wrap_add = sum_s - modulus;
        end else begin
            wrap_add = sum_s;
        end
    endfunction

    function automatic logic [6:0] hour_modulus(input int mode_24h);
        hour_modulus = (mode_24h != 0) ? 7'd24 : 7'd12;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: alarm time, OFF/ARMED/RINGING state machine and tick counter.
// TIMEKEEPER_SNOOZE_EN adds the snooze input and the SNOOZED state.
module alarm_channel
    import timekeeper_pkg::*;
#(
    parameter int MODE_24H       = 0,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       video_clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       sel,
    input  logic       al_inc_min,
    input  logic       al_inc_hr,
    input  logic       al_toggle,
    input  logic       dismiss,
`ifdef TIMEKEEPER_SNOOZE_EN
    input  logic       snooze,
`endif
    input  logic [4:0] next_hours,
    input  logic [5:0] next_minutes,
    input  logic [5:0] next_seconds,
    output logic       al_enabled,
    output logic       al_ringing
);

    localparam logic [6:0] HR_MOD = hour_modulus(MODE_24H);

    alarm_state_t state_r;
    alarm_state_t state_next_s;
    logic [4:0]   al_hr_r;
    logic [5:0]   al_min_r;
    logic [15:0]  cnt_r;
    logic         enabled_r;
    logic         ringing_r;
    logic         enabled_next_s;
    logic         ringing_next_s;
    logic         toggle_s;
    logic         match_s;
    logic         timeout_s;

    // Only a tick-driven arrival at hh:mm:00 counts as an alarm match.
    assign toggle_s  = sel && al_toggle;
    assign match_s   = sec_tick && (next_seconds == 6'd0) &&
                       (next_minutes == al_min_r) && (next_hours == al_hr_r);
    assign timeout_s = sec_tick && (cnt_r == 16'(RING_TIMEOUT_S - 1));

    // State register with registered flag outputs.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            state_r   <= AL_OFF;
            enabled_r <= 1'b0;
            ringing_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            enabled_r <= enabled_next_s;
            ringing_r <= ringing_next_s;
        end
    end

    // Next state: toggle outranks dismiss, snooze, timeout and match.
    always_comb begin
        state_next_s = state_r;
        if (toggle_s) begin
            state_next_s = (state_r == AL_OFF) ? AL_ARMED : AL_OFF;
        end else begin
            case (state_r)
                AL_OFF:   state_next_s = AL_OFF;
                AL_ARMED: state_next_s = match_s ? AL_RINGING : AL_ARMED;
                AL_RINGING: begin
                    if (dismiss) begin
                        state_next_s = AL_ARMED;
`ifdef TIMEKEEPER_SNOOZE_EN
                    end else if (snooze) begin
                        state_next_s = AL_SNOOZED;
`endif
                    end else if (timeout_s) begin
                        state_next_s = AL_ARMED;
                    end else begin
                        state_next_s = AL_RINGING;
                    end
                end
`ifdef TIMEKEEPER_SNOOZE_EN
                AL_SNOOZED: begin
                    if (dismiss) begin
                        state_next_s = AL_ARMED;
                    end else if (sec_tick && (cnt_r == 16'(SNOOZE_S - 1))) begin
                        state_next_s = AL_RINGING;
                    end else begin
                        state_next_s = AL_SNOOZED;
                    end
                end
`endif
                default:  state_next_s = AL_OFF;
            endcase
        end
    end

    // Output decode from the next state so the flags come straight off flops.
    always_comb begin
        enabled_next_s = (state_next_s != AL_OFF);
        ringing_next_s = (state_next_s == AL_RINGING);
    end

    // Seconds spent in the current ringing (or snoozed) stay; cleared on every transition.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 16'd0;
        end else if (state_next_s != state_r) begin
            cnt_r <= 16'd0;
`ifdef TIMEKEEPER_SNOOZE_EN
        end else if (sec_tick && ((state_r == AL_RINGING) || (state_r == AL_SNOOZED))) begin
`else
        end else if (sec_tick && (state_r == AL_RINGING)) begin
`endif
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Alarm time adjust; minutes never carry into hours.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            al_hr_r  <= 5'd0;
            al_min_r <= 6'd0;
        end else begin
            if (sel && al_inc_min) begin
                al_min_r <= 6'(wrap_add({1'b0, al_min_r}, 2'd1, 7'(MIN_MAX + 1)));
            end
            if (sel && al_inc_hr) begin
                al_hr_r <= 5'(wrap_add({2'b00, al_hr_r}, 2'd1, HR_MOD));
            end
        end
    end

    assign al_enabled = enabled_r;
    assign al_ringing = ringing_r;

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Time-of-day counter with NUM_ALARMS alarm channels and a gated buzzer.
// Define TIMEKEEPER_SNOOZE_EN to add the snooze input and SNOOZED alarm state.
module multi_alarm_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int CLK_HZ         = 31_500_000,
    parameter int NUM_ALARMS     = 2,
    parameter int MODE_24H       = 0,
    parameter int BUZZ_HALF      = 5000,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                  video_clk,
    input  logic                  reset,
    input  logic                  inc_sec,
    input  logic                  inc_min,
    input  logic                  inc_hr,
    input  logic [2:0]            al_sel,
    input  logic                  al_inc_min,
    input  logic                  al_inc_hr,
    input  logic                  al_toggle,
    input  logic                  dismiss,
`ifdef TIMEKEEPER_SNOOZE_EN
    input  logic                  snooze,
`endif
    output logic [5:0]            seconds,
    output logic [5:0]            minutes,
    output logic [4:0]            hours,
    output logic [NUM_ALARMS-1:0] al_enabled,
    output logic [NUM_ALARMS-1:0] al_ringing,
    output logic                  sec_tick,
    output logic                  half_sec,
    output logic                  buzzer_out
);

    localparam int         PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int         BZ_W   = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;
    localparam logic [6:0] HR_MOD = hour_modulus(MODE_24H);

    logic [PS_W-1:0] prescale_r;
    logic [PS_W-1:0] prescale_next_s;
    logic            sec_tick_r;
    logic            half_sec_r;
    logic [5:0]      sec_r;
    logic [5:0]      min_r;
    logic [4:0]      hr_r;
    logic [5:0]      sec_next_s;
    logic [5:0]      min_next_s;
    logic [4:0]      hr_next_s;
    logic            carry_min_s;
    logic            carry_hr_s;
    logic [BZ_W-1:0] buzz_cnt_r;
    logic            buzzer_r;
    logic            buzz_active_s;

    always_comb begin
        if (prescale_r == PS_W'(CLK_HZ - 1)) begin
            prescale_next_s = {PS_W{1'b0}};
        end else begin
            prescale_next_s = prescale_r + PS_W'(1);
        end
    end

    // sec_tick and half_sec are registered from the next prescaler value so they
    // line up exactly with the prescaler count they describe.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            prescale_r <= {PS_W{1'b0}};
            sec_tick_r <= 1'b0;
            half_sec_r <= 1'b0;
        end else begin
            prescale_r <= prescale_next_s;
            sec_tick_r <= (prescale_next_s == PS_W'(CLK_HZ - 1));
            half_sec_r <= (prescale_next_s >= PS_W'(CLK_HZ / 2));
        end
    end

    // Ticks ripple carries upward in one cycle; adjust pulses never carry.
    always_comb begin
        carry_min_s = sec_tick_r && (sec_r == 6'(SEC_MAX));
        carry_hr_s  = carry_min_s && (min_r == 6'(MIN_MAX));
        sec_next_s  = 6'(wrap_add({1'b0, sec_r}, {1'b0, sec_tick_r} + {1'b0, inc_sec}, 7'(SEC_MAX + 1)));
        min_next_s  = 6'(wrap_add({1'b0, min_r}, {1'b0, carry_min_s} + {1'b0, inc_min}, 7'(MIN_MAX + 1)));
        hr_next_s   = 5'(wrap_add({2'b00, hr_r}, {1'b0, carry_hr_s} + {1'b0, inc_hr}, HR_MOD));
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            sec_r <= 6'd0;
            min_r <= 6'd0;
            hr_r  <= 5'd0;
        end else begin
            sec_r <= sec_next_s;
            min_r <= min_next_s;
            hr_r  <= hr_next_s;
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        alarm_channel #(
            .MODE_24H       (MODE_24H),
            .RING_TIMEOUT_S (RING_TIMEOUT_S)
        ) u_chan (
            .video_clk    (video_clk),
            .reset        (reset),
            .sec_tick     (sec_tick_r),
            .sel          (al_sel == 3'(i)),
            .al_inc_min   (al_inc_min),
            .al_inc_hr    (al_inc_hr),
            .al_toggle    (al_toggle),
            .dismiss      (dismiss),
`ifdef TIMEKEEPER_SNOOZE_EN
            .snooze       (snooze),
`endif
            .next_hours   (hr_next_s),
            .next_minutes (min_next_s),
            .next_seconds (sec_next_s),
            .al_enabled   (al_enabled[i]),
            .al_ringing   (al_ringing[i])
        );
    end

    assign buzz_active_s = (|al_ringing) && half_sec_r;

    // Buzzer runs only in the high half-second while something rings.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            buzz_cnt_r <= {BZ_W{1'b0}};
            buzzer_r   <= 1'b0;
        end else if (!buzz_active_s) begin
            buzz_cnt_r <= {BZ_W{1'b0}};
            buzzer_r   <= 1'b0;
        end else if (buzz_cnt_r == BZ_W'(BUZZ_HALF - 1)) begin
            buzz_cnt_r <= {BZ_W{1'b0}};
            buzzer_r   <= ~buzzer_r;
        end else begin
            buzz_cnt_r <= buzz_cnt_r + BZ_W'(1);
            buzzer_r   <= buzzer_r;
        end
    end

    assign seconds    = sec_r;
    assign minutes    = min_r;
    assign hours      = hr_r;
    assign sec_tick   = sec_tick_r;
    assign half_sec   = half_sec_r;
    assign buzzer_out = buzzer_r;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Randomized bench for multi_alarm_timekeeper against a field-level time/alarm model.
// Honours TIMEKEEPER_SNOOZE_EN when the design is built with it.
module tb_multi_alarm_timekeeper;

    localparam int CLK_HZ = 10;
    localparam int NA     = 2;
    localparam int BZ     = 2;
    localparam int TO     = 60;
    localparam int HRM    = 12;
    localparam int S_OFF  = 0;
    localparam int S_ARM  = 1;
    localparam int S_RING = 2;
    localparam int S_SNZ  = 3;

    logic          video_clk = 1'b0;
    logic          reset;
    logic          inc_sec, inc_min, inc_hr;
    logic [2:0]    al_sel;
    logic          al_inc_min, al_inc_hr, al_toggle, dismiss;
    logic          snooze;
    logic [5:0]    seconds, minutes;
    logic [4:0]    hours;
    logic [NA-1:0] al_enabled, al_ringing;
    logic          sec_tick, half_sec, buzzer_out;

    int n_total = 0;
    int n_bad   = 0;

    int m_ps, m_s, m_m, m_h, m_run, m_buzz;
    int m_alh[NA];
    int m_alm[NA];
    int m_st[NA];
    int m_cnt[NA];

    multi_alarm_timekeeper #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .MODE_24H(0), .BUZZ_HALF(BZ), .RING_TIMEOUT_S(TO)
    ) dut (
        .video_clk  (video_clk),
        .reset      (reset),
        .inc_sec    (inc_sec),
        .inc_min    (inc_min),
        .inc_hr     (inc_hr),
        .al_sel     (al_sel),
        .al_inc_min (al_inc_min),
        .al_inc_hr  (al_inc_hr),
        .al_toggle  (al_toggle),
        .dismiss    (dismiss),
`ifdef TIMEKEEPER_SNOOZE_EN
        .snooze     (snooze),
`endif
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .al_enabled (al_enabled),
        .al_ringing (al_ringing),
        .sec_tick   (sec_tick),
        .half_sec   (half_sec),
        .buzzer_out (buzzer_out)
    );

    always #5 video_clk = ~video_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ps = 0; m_s = 0; m_m = 0; m_h = 0; m_run = 0; m_buzz = 0;
        for (int c = 0; c < NA; c++) begin
            m_alh[c] = 0; m_alm[c] = 0; m_st[c] = S_OFF; m_cnt[c] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs just sampled.
    task automatic model_step();
        int tick, cs, cm, ns, nm, nh, anyr;
        tick = (m_ps == CLK_HZ - 1) ? 1 : 0;
        anyr = 0;
        for (int c = 0; c < NA; c++) if (m_st[c] == S_RING) anyr = 1;
        if (anyr != 0 && m_ps >= CLK_HZ / 2) begin
            m_run++;
            m_buzz = (m_run / BZ) % 2;
        end else begin
            m_run = 0;
            m_buzz = 0;
        end
        cs = (tick != 0 && m_s == 59) ? 1 : 0;
        cm = (cs != 0 && m_m == 59) ? 1 : 0;
        ns = (m_s + tick + int'(inc_sec)) % 60;
        nm = (m_m + cs + int'(inc_min)) % 60;
        nh = (m_h + cm + int'(inc_hr)) % HRM;
        for (int c = 0; c < NA; c++) begin
            if (int'(al_sel) == c && al_toggle) begin
                m_st[c] = (m_st[c] == S_OFF) ? S_ARM : S_OFF;
                m_cnt[c] = 0;
            end else if (m_st[c] == S_ARM) begin
                if (tick != 0 && ns == 0 && nm == m_alm[c] && nh == m_alh[c]) begin
                    m_st[c] = S_RING;
                    m_cnt[c] = 0;
                end
            end else if (m_st[c] == S_RING) begin
                if (dismiss) m_st[c] = S_ARM;
`ifdef TIMEKEEPER_SNOOZE_EN
                else if (snooze) begin m_st[c] = S_SNZ; m_cnt[c] = 0; end
`endif
                else if (tick != 0) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == TO) m_st[c] = S_ARM;
                end
            end else if (m_st[c] == S_SNZ) begin
                if (dismiss) m_st[c] = S_ARM;
                else if (tick != 0) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == 300) begin m_st[c] = S_RING; m_cnt[c] = 0; end
                end
            end
            if (int'(al_sel) == c && al_inc_min) m_alm[c] = (m_alm[c] + 1) % 60;
            if (int'(al_sel) == c && al_inc_hr)  m_alh[c] = (m_alh[c] + 1) % HRM;
        end
        m_s = ns; m_m = nm; m_h = nh;
        m_ps = (m_ps + 1) % CLK_HZ;
    endtask

    task automatic compare_all();
        logic [NA-1:0] exp_en, exp_ring;
        for (int c = 0; c < NA; c++) begin
            exp_en[c]   = (m_st[c] != S_OFF);
            exp_ring[c] = (m_st[c] == S_RING);
        end
        check_eq("seconds", seconds, m_s);
        check_eq("minutes", minutes, m_m);
        check_eq("hours", hours, m_h);
        check_eq("sec_tick", sec_tick, (m_ps == CLK_HZ - 1) ? 1 : 0);
        check_eq("half_sec", half_sec, (m_ps >= CLK_HZ / 2) ? 1 : 0);
        check_eq("buzzer_out", buzzer_out, m_buzz);
        check_eq("al_enabled", al_enabled, exp_en);
        check_eq("al_ringing", al_ringing, exp_ring);
    endtask

    // Run one clock with the currently driven inputs, then drop all pulses.
    task automatic cyc();
        @(posedge video_clk);
        model_step();
        #1;
        compare_all();
        inc_sec = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        al_inc_min = 1'b0; al_inc_hr = 1'b0; al_toggle = 1'b0; dismiss = 1'b0; snooze = 1'b0;
    endtask

    // Adjust the time until the DUT sits in a tick cycle showing th:tm:ts.
    task automatic steer(input int th, input int tm, input int ts);
        int guard = 0;
        while (!(m_ps == CLK_HZ - 1 && m_h == th && m_m == tm && m_s == ts) && guard < 3000) begin
            if (m_ps != CLK_HZ - 1) begin
                inc_hr  = (m_h != th);
                inc_min = (m_m != tm);
                inc_sec = (m_s != ts);
            end
            cyc();
            guard++;
        end
        check_eq("steer_reached", (guard < 3000) ? 1 : 0, 1);
    endtask

    task automatic set_alarm(input int ch, input int h, input int mi);
        int guard = 0;
        al_sel = 3'(ch);
        while ((m_alh[ch] != h || m_alm[ch] != mi) && guard < 200) begin
            al_inc_hr  = (m_alh[ch] != h);
            al_inc_min = (m_alm[ch] != mi);
            cyc();
            guard++;
        end
        if (m_st[ch] == S_OFF) begin
            al_toggle = 1'b1;
            cyc();
        end
        check_eq("alarm_armed", al_enabled[ch], 1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("reset_time", {hours, minutes, seconds}, 0);
        check_eq("reset_flags", {al_enabled, al_ringing, sec_tick, half_sec, buzzer_out}, 0);
        model_reset();
        @(negedge video_clk);
        reset = 1'b0;
    endtask

    initial begin
        int first, ticks, guard, ch, h, mi, ph, pm;
        reset = 1'b1; al_sel = 3'd0;
        inc_sec = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        al_inc_min = 1'b0; al_inc_hr = 1'b0; al_toggle = 1'b0; dismiss = 1'b0; snooze = 1'b0;
        #12;
        do_reset();

        first = -1;
        for (int k = 1; k <= 3 * CLK_HZ; k++) begin
            cyc();
            if (first < 0 && seconds == 6'd1) first = k;
        end
        check_eq("first_tick_latency", first, CLK_HZ);

        steer(11, 59, 59);
        cyc();
        check_eq("rollover_12h", {hours, minutes, seconds}, 0);

        steer(3, 10, 59);
        inc_sec = 1'b1;
        cyc();
        check_eq("inc_on_tick_sec", seconds, 1);
        check_eq("inc_on_tick_min", minutes, 11);

        set_alarm(0, 7, 30);
        steer(7, 29, 59);
        cyc();
        check_eq("ring_start", al_ringing[0], 1);
        ticks = 0; guard = 0;
        while (al_ringing[0] && guard < 1000) begin
            if (sec_tick) ticks++;
            cyc();
            guard++;
        end
        check_eq("timeout_ticks", ticks, TO);
        check_eq("timeout_armed", al_enabled[0], 1);

        set_alarm(0, 7, 32);
        steer(7, 31, 59);
        cyc();
        check_eq("ring_start2", al_ringing[0], 1);
        for (int k = 0; k < 7; k++) cyc();
        dismiss = 1'b1;
        cyc();
        check_eq("dismiss_fall", al_ringing[0], 0);

        al_sel = 3'd5; al_toggle = 1'b1;
        cyc();
        check_eq("sel_out_of_range", al_enabled, 2'b01);

        set_alarm(0, 7, 35);
        steer(7, 34, 59);
        cyc();
        for (int k = 0; k < 4; k++) cyc();
        check_eq("ring_before_reset", al_ringing[0], 1);
        do_reset();

`ifdef TIMEKEEPER_SNOOZE_EN
        set_alarm(1, 2, 5);
        steer(2, 4, 59);
        cyc();
        check_eq("snooze_ring", al_ringing[1], 1);
        snooze = 1'b1;
        cyc();
        check_eq("snooze_quiet", al_ringing[1], 0);
        ticks = 0; guard = 0;
        while (!al_ringing[1] && guard < 4000) begin
            if (sec_tick) ticks++;
            cyc();
            guard++;
        end
        check_eq("snooze_ticks", ticks, 300);
        dismiss = 1'b1;
        cyc();
`endif

        for (int it = 0; it < 4; it++) begin
            ch = $urandom_range(0, NA - 1);
            h  = $urandom_range(0, HRM - 1);
            mi = $urandom_range(0, 59);
            pm = (mi == 0) ? 59 : mi - 1;
            ph = (mi == 0) ? (h + HRM - 1) % HRM : h;
            set_alarm(ch, h, mi);
            steer(ph, pm, 59);
            for (int k = 0; k < 250; k++) begin
                dismiss = ($urandom_range(0, 63) == 0);
                cyc();
            end
        end

        for (int k = 0; k < 3000; k++) begin
            al_sel     = 3'($urandom_range(0, 7));
            inc_sec    = ($urandom_range(0, 15) == 0);
            inc_min    = ($urandom_range(0, 15) == 0);
            inc_hr     = ($urandom_range(0, 15) == 0);
            al_inc_min = ($urandom_range(0, 15) == 0);
            al_inc_hr  = ($urandom_range(0, 15) == 0);
            al_toggle  = ($urandom_range(0, 39) == 0);
            dismiss    = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_alarm_timekeeper.md
MULTI_ALARM_TIMEKEEPER -- requirements
Module: multi_alarm_timekeeper

Interface
REQ-001 Parameter CLK_HZ, default 31_500_000, video_clk cycles per second.
REQ-002 Parameter NUM_ALARMS, default 2, independent alarm channels (1..8).
REQ-003 Parameter MODE_24H, default 0: hours wrap at 12 when 0, at 24 when 1.
REQ-004 Parameter BUZZ_HALF, default 5000, video_clk cycles per buzzer half-period.
REQ-005 Parameter RING_TIMEOUT_S, default 60, seconds a channel rings before auto-stop.
REQ-006 Ports (clock and reset first): video_clk in 1 clock; reset in 1 asynchronous, active-high; clock video_clk.
REQ-007 inc_sec / inc_min / inc_hr  in  1 each  single-cycle debounced time-adjust pulses.
REQ-008 al_sel  in  3  target channel for alarm adjust/toggle pulses; values >= NUM_ALARMS ignored.
REQ-009 al_inc_min / al_inc_hr / al_toggle / dismiss  in  1 each  single-cycle pulses.
REQ-010 seconds out 6, minutes out 6, hours out 5: current time, registered.
REQ-011 al_enabled / al_ringing  out  NUM_ALARMS  per-channel armed and ringing flags.
REQ-012 sec_tick  out  1  one-cycle pulse per elapsed second; half_sec  out  1  50% 1 Hz square wave.
REQ-013 buzzer_out  out  1  audio square wave, registered.

Function
REQ-014 Prescaler counts 0..CLK_HZ-1; sec_tick asserts the cycle it equals CLK_HZ-1, then wraps to 0.
REQ-015 half_sec is 0 for prescaler < CLK_HZ/2, else 1.
REQ-016 On sec_tick: seconds 59->0 carries minutes; minutes 59->0 carries hours; hours wrap 11->0 (or 23->0); all in the same cycle.
REQ-017 inc_sec/inc_min/inc_hr increment their field modulo its range with no carry into the next field.
REQ-018 sec_tick and inc_sec in the same cycle: seconds advance by 2 modulo 60; carry to minutes only if seconds was 59 before the cycle; same rule for minute and hour fields.
REQ-019 Per-channel alarm time al_hr/al_min, reset 0; al_inc_min adds 1 modulo 60 (no carry), al_inc_hr adds 1 modulo hour range.
REQ-020 Per-channel FSM OFF, ARMED, RINGING (plus SNOOZED when configured); al_enabled = state != OFF; al_ringing = state == RINGING.
REQ-021 OFF --al_toggle--> ARMED; any other state --al_toggle--> OFF.
REQ-022 ARMED -> RINGING on the cycle after a sec_tick that makes hours==al_hr, minutes==al_min, seconds==0.
REQ-023 RINGING -> ARMED on dismiss, or after RING_TIMEOUT_S sec_ticks in RINGING.
REQ-024 al_toggle takes priority over dismiss and match in the same cycle.
REQ-025 buzzer_out toggles every BUZZ_HALF cycles while any channel RINGING and half_sec=1; otherwise 0 registered next cycle.
REQ-026 Manual time adjustment landing on a match (seconds==0) does not trigger RINGING; only sec_tick-driven matches trigger.

Reset
REQ-027 Reset asserted at any time forces all counters, time fields, alarm times, FSMs (OFF) and every output to 0 asynchronously.
REQ-028 First sec_tick occurs CLK_HZ cycles after reset deassertion.

Configuration
REQ-029 Macro TIMEKEEPER_SNOOZE_EN defined: snooze input port (1 bit, pulse) exists; RINGING --snooze--> SNOOZED; SNOOZED --> RINGING after 300 sec_ticks; dismiss or al_toggle leaves SNOOZED as REQ-021/023.
REQ-030 Macro undefined: no snooze port, no SNOOZED state, no snooze counter logic.

Structure
REQ-031 Package timekeeper_pkg holds the alarm-state enum, SEC_MAX=59, MIN_MAX=59, SNOOZE_S=300.
REQ-032 One sub-module alarm_channel (FSM, alarm time, timeout/snooze counter), instantiated NUM_ALARMS times by generate.

Verification (CLK_HZ=10, BUZZ_HALF=2)
REQ-033 Time 11:59:59, MODE_24H=0, one sec_tick -> 00:00:00 the cycle after the tick.
REQ-034 Ch0 armed at 07:30, time 07:29:59, tick -> al_ringing[0]=1 next cycle; buzzer_out toggles every 2 cycles in half_sec high, 0 in low.
REQ-035 Ringing ch0, no dismiss -> al_ringing[0] falls after 60 ticks, state ARMED; dismiss instead -> falls next cycle.
REQ-036 seconds=59, inc_sec coincident with sec_tick -> seconds=1, minutes+1.
REQ-037 al_sel=5 with NUM_ALARMS=2, al_toggle -> no al_enabled change; reset mid-ring -> all outputs 0 immediately.
REQ-038 With TIMEKEEPER_SNOOZE_EN: snooze during ring -> al_ringing=0, re-rings after exactly 300 ticks.
